// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: turns a core read request into a byte-serial exchange.
// The 32-bit address goes out as 4 bytes (LSB first) on the transmit
// stream; 4 reply bytes (LSB first) are gathered from the receive stream
// and the assembled word is returned with a one-cycle ready pulse.
// A silent link is caught by a per-byte watchdog that ends the request
// with mem_err_o set and a zero data word.
module uart_mem_bridge #(
   parameter logic [31:0] TimeoutCycles = 32'd1000000
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        mem_valid_i,
   input  logic [31:0] mem_addr_i,
   output logic        mem_ready_o,
   output logic [31:0] mem_rdata_o,
   output logic        mem_err_o,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      RECV = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state, state_nx;
   logic [1:0]  idx, idx_nx;
   logic [31:0] addr, addr_nx;
   logic [31:0] timer, timer_nx;
   logic [31:0] rdata, rdata_nx;
   logic        err_nx;
   logic        tvalid_nx;
   logic [7:0]  tdata_nx;
   logic        rx_ready_nx;
   logic        ready_nx;
   logic        tx_hs;
   logic        rx_hs;

   // Pick byte lane n of a word (lane 0 is bits 7:0).
   function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] n);
      logic [7:0] b;
      case (n)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      return b;
   endfunction

   // Replace byte lane n of a word with b.
   function automatic logic [31:0] byte_put(input logic [31:0] word, input logic [1:0] n,
                                            input logic [7:0] b);
      logic [31:0] w;
      w = word;
      case (n)
         2'd0:    w[7:0]   = b;
         2'd1:    w[15:8]  = b;
         2'd2:    w[23:16] = b;
         default: w[31:24] = b;
      endcase
      return w;
   endfunction

   // Stream outputs are registered, so a handshake is judged on the
   // values the partner currently sees.
   assign tx_hs = m_axis_tvalid & m_axis_tready;
   assign rx_hs = s_axis_tvalid & s_axis_tready;

   // Next-state, datapath updates and next values of the registered outputs.
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      addr_nx  = addr;
      timer_nx = timer;
      rdata_nx = rdata;
      err_nx   = 1'b0;

      case (state)
         IDLE: begin
            if (mem_valid_i) begin
               addr_nx  = mem_addr_i;
               idx_nx   = 2'd0;
               state_nx = SEND;
            end
         end
         SEND: begin
            if (tx_hs) begin
               if (idx == 2'd3) begin
                  state_nx = RECV;
                  idx_nx   = 2'd0;
                  timer_nx = 32'd0;
               end else begin
                  idx_nx = idx + 2'd1;
               end
            end
         end
         RECV: begin
            // A byte landing on the expiry cycle wins over the watchdog.
            if (rx_hs) begin
               rdata_nx = byte_put(rdata, idx, s_axis_tdata);
               timer_nx = 32'd0;
               if (idx == 2'd3) begin
                  state_nx = DONE;
               end else begin
                  idx_nx = idx + 2'd1;
               end
            end else if (timer == TimeoutCycles - 32'd2) begin
               // The count is about to reach TimeoutCycles-1: give up,
               // dropping any partially collected bytes.
               state_nx = DONE;
               err_nx   = 1'b1;
               rdata_nx = 32'd0;
               timer_nx = timer + 32'd1;
            end else begin
               timer_nx = timer + 32'd1;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      // Outputs belong to the state being entered, so they are correct on
      // the first cycle of that state and read as zero while in reset.
      tvalid_nx   = (state_nx == SEND);
      tdata_nx    = (state_nx == SEND) ? byte_sel(addr_nx, idx_nx) : 8'h00;
      rx_ready_nx = (state_nx == IDLE) || (state_nx == RECV);
      ready_nx    = (state_nx == DONE);
   end

   // State register; reset forces IDLE at once.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Byte index, latched address, watchdog, data word and registered outputs.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         idx           <= 2'd0;
         addr          <= 32'd0;
         timer         <= 32'd0;
         rdata         <= 32'd0;
         mem_ready_o   <= 1'b0;
         mem_err_o     <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= 8'h00;
         s_axis_tready <= 1'b0;
      end else begin
         idx           <= idx_nx;
         addr          <= addr_nx;
         timer         <= timer_nx;
         rdata         <= rdata_nx;
         mem_ready_o   <= ready_nx;
         mem_err_o     <= err_nx;
         m_axis_tvalid <= tvalid_nx;
         m_axis_tdata  <= tdata_nx;
         s_axis_tready <= rx_ready_nx;
      end
   end

   assign mem_rdata_o = rdata;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Bench for uart_mem_bridge: table-driven fetches, randomized fetches and
// hand-written sequences for timeout, stray bytes, async reset and
// back-to-back requests. Expected values come from a word-level model.
module tb_uart_mem_bridge;

   localparam logic [31:0] TO = 32'd16;

   logic        clk_i = 1'b0;
   logic        reset_ni = 1'b0;
   logic        mem_valid_i = 1'b0;
   logic [31:0] mem_addr_i = 32'd0;
   logic        mem_ready_o;
   logic [31:0] mem_rdata_o;
   logic        mem_err_o;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic [7:0]  s_axis_tdata = 8'h00;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;

   uart_mem_bridge #(.TimeoutCycles(TO)) dut (
      .clk_i         (clk_i),
      .reset_ni      (reset_ni),
      .mem_valid_i   (mem_valid_i),
      .mem_addr_i    (mem_addr_i),
      .mem_ready_o   (mem_ready_o),
      .mem_rdata_o   (mem_rdata_o),
      .mem_err_o     (mem_err_o),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int tr_mode = 0;
   int pulses = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   // Reference model: word from LSB-first bytes, and the i-th address byte.
   function automatic logic [31:0] model_word(input logic [7:0] b [4]);
      logic [31:0] w = 32'd0;
      for (int i = 3; i >= 0; i--) w = (w << 8) | 32'(b[i]);
      return w;
   endfunction

   function automatic logic [7:0] model_txb(input logic [31:0] a, input int i);
      return 8'((a >> (8 * i)) & 32'hff);
   endfunction

   // Transmit-side acceptance pattern.
   initial begin
      int cnt = 0;
      forever begin
         @(posedge clk_i);
         #1;
         cnt++;
         case (tr_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = (cnt % 3 == 0);
            default: m_axis_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Transmit monitor: log accepted bytes, and check stability under stall.
   logic [7:0] tx_q [$];
   logic       prev_v = 1'b0;
   logic       prev_hs = 1'b0;
   logic [7:0] prev_d = 8'h00;
   logic       prev_rdy = 1'b0;
   always @(negedge clk_i) begin
      if (reset_ni) begin
         if (prev_v && !prev_hs) begin
            check("tvalid_hold", 32'(m_axis_tvalid), 32'd1);
            check("tdata_hold", 32'(m_axis_tdata), 32'(prev_d));
         end
         if (m_axis_tvalid && m_axis_tready) tx_q.push_back(m_axis_tdata);
         if (mem_ready_o) begin
            pulses++;
            check("ready_width", 32'(prev_rdy), 32'd0);
         end
      end
      prev_v   = m_axis_tvalid;
      prev_d   = m_axis_tdata;
      prev_hs  = m_axis_tvalid && m_axis_tready;
      prev_rdy = mem_ready_o;
   end

   task automatic wait_tvalid();
      bit seen = 0;
      int n = 0;
      while (!seen && n < 3000) begin
         @(negedge clk_i);
         if (m_axis_tvalid) seen = 1;
         n++;
      end
      if (!seen) fail_now("wait_tvalid");
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_ready(output logic [31:0] rd, output logic er, output int at);
      bit seen = 0;
      int n = 0;
      rd = 32'd0;
      er = 1'b0;
      at = -1;
      while (!seen && n < 3000) begin
         @(negedge clk_i);
         if (mem_ready_o) begin
            seen = 1;
            rd = mem_rdata_o;
            er = mem_err_o;
            at = cyc;
         end
         n++;
      end
      if (!seen) fail_now("wait_ready");
      @(posedge clk_i);
      #1;
   endtask

   task automatic rx_byte(input logic [7:0] b, input int gap, output int hs_at);
      bit done = 0;
      int n = 0;
      hs_at = -1;
      s_axis_tvalid = 1'b0;
      repeat (gap) begin
         @(posedge clk_i);
         #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b;
      while (!done && n < 3000) begin
         @(negedge clk_i);
         if (s_axis_tready) begin
            done  = 1;
            hs_at = cyc;
         end
         @(posedge clk_i);
         #1;
         n++;
      end
      s_axis_tvalid = 1'b0;
      if (!done) fail_now("rx_byte");
   endtask

   // One request; gap < 0 picks a random 0..4 cycle gap before each reply byte.
   task automatic fetch(input logic [31:0] a, input logic [7:0] rxb [4], input int gap,
                        input int nbytes, output logic [31:0] rd, output logic er,
                        output int lat, output int to_gap);
      int t0, at, last_hs;
      last_hs = 0;
      at = 0;
      tx_q.delete();
      mem_addr_i  = a;
      mem_valid_i = 1'b1;
      t0 = cyc;
      fork
         begin
            int hs;
            wait_tvalid();
            for (int i = 0; i < nbytes; i++) begin
               rx_byte(rxb[i], (gap < 0) ? int'($urandom_range(0, 4)) : gap, hs);
               last_hs = hs;
            end
         end
         wait_ready(rd, er, at);
      join
      mem_valid_i = 1'b0;
      lat = at - t0;
      to_gap = at - last_hs;
   endtask

   task automatic check_tx(input logic [31:0] a, input string tag);
      check({tag, "_txcount"}, 32'(tx_q.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < tx_q.size()) check({tag, "_txbyte"}, 32'(tx_q[i]), 32'(model_txb(a, i)));
   endtask

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [7:0]  rxb [4];
      int          mode;
      int          gap;
      int          nbytes;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
      int          exp_to;
   } vec_t;

   vec_t tbl [4];

   task automatic run_vec(input vec_t v);
      logic [31:0] rd;
      logic er;
      int lat, tg;
      tr_mode = v.mode;
      fetch(v.addr, v.rxb, v.gap, v.nbytes, rd, er, lat, tg);
      check({v.name, "_rdata"}, rd, v.exp_rd);
      check({v.name, "_err"}, 32'(er), 32'(v.exp_err));
      if (v.exp_lat >= 0) check({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
      if (v.exp_to >= 0) check({v.name, "_timeout_gap"}, 32'(tg), 32'(v.exp_to));
      check_tx(v.addr, v.name);
   endtask

   initial begin
      logic [31:0] rd, rd1, rd2;
      logic er, er1, er2;
      int lat, tg, hs, a1, a2, p0;
      logic [7:0] b [4];
      logic [7:0] b2 [4];

      tbl[0].name = "basic";   tbl[0].addr = 32'h0000_0008; tbl[0].rxb = '{8'h6f, 8'hf0, 8'h5f, 8'hff};
      tbl[0].mode = 0; tbl[0].gap = 0; tbl[0].nbytes = 4; tbl[0].exp_rd = 32'hff5f_f06f;
      tbl[0].exp_err = 1'b0; tbl[0].exp_lat = 9; tbl[0].exp_to = -1;
      tbl[1].name = "backpr";  tbl[1].addr = 32'h0000_03fc; tbl[1].rxb = '{8'h13, 8'h00, 8'h00, 8'h00};
      tbl[1].mode = 1; tbl[1].gap = 0; tbl[1].nbytes = 4; tbl[1].exp_rd = 32'h0000_0013;
      tbl[1].exp_err = 1'b0; tbl[1].exp_lat = -1; tbl[1].exp_to = -1;
      tbl[2].name = "timeout"; tbl[2].addr = 32'h0000_0020; tbl[2].rxb = '{8'hdd, 8'hcc, 8'hbb, 8'haa};
      tbl[2].mode = 0; tbl[2].gap = 0; tbl[2].nbytes = 2; tbl[2].exp_rd = 32'h0000_0000;
      tbl[2].exp_err = 1'b1; tbl[2].exp_lat = -1; tbl[2].exp_to = 16;
      tbl[3].name = "after_to"; tbl[3].addr = 32'h8000_0024; tbl[3].rxb = '{8'h78, 8'h56, 8'h34, 8'h12};
      tbl[3].mode = 0; tbl[3].gap = 2; tbl[3].nbytes = 4; tbl[3].exp_rd = 32'h1234_5678;
      tbl[3].exp_err = 1'b0; tbl[3].exp_lat = -1; tbl[3].exp_to = -1;

      // Reset state.
      #12;
      check("rst_ready", 32'(mem_ready_o), 32'd0);
      check("rst_rdata", mem_rdata_o, 32'd0);
      check("rst_err", 32'(mem_err_o), 32'd0);
      check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_tdata", 32'(m_axis_tdata), 32'd0);
      check("rst_rxready", 32'(s_axis_tready), 32'd0);
      @(posedge clk_i);
      #1;
      reset_ni = 1'b1;
      repeat (2) begin
         @(posedge clk_i);
         #1;
      end
      check("idle_rxready", 32'(s_axis_tready), 32'd1);

      for (int i = 0; i < 4; i++) run_vec(tbl[i]);

      // Stray bytes in IDLE are swallowed; the next fetch is unaffected.
      tr_mode = 0;
      for (int i = 0; i < 3; i++) begin
         rx_byte(8'(8'h a0 + i), 0, hs);
         check("stray_accepted", 32'(hs >= 0), 32'd1);
      end
      b = '{8'hef, 8'hbe, 8'had, 8'hde};
      fetch(32'h10, b, 0, 4, rd, er, lat, tg);
      check("stray_rdata", rd, model_word(b));
      check("stray_err", 32'(er), 32'd0);
      check_tx(32'h10, "stray");

      // Asynchronous reset while collecting reply bytes.
      tx_q.delete();
      mem_addr_i  = 32'h40;
      mem_valid_i = 1'b1;
      wait_tvalid();
      rx_byte(8'h5a, 0, hs);
      rx_byte(8'ha5, 0, hs);
      #2;
      reset_ni = 1'b0;
      #1;
      check("arst_ready", 32'(mem_ready_o), 32'd0);
      check("arst_rdata", mem_rdata_o, 32'd0);
      check("arst_err", 32'(mem_err_o), 32'd0);
      check("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("arst_tdata", 32'(m_axis_tdata), 32'd0);
      check("arst_rxready", 32'(s_axis_tready), 32'd0);
      mem_valid_i = 1'b0;
      repeat (2) begin
         @(posedge clk_i);
         #1;
      end
      reset_ni = 1'b1;
      @(posedge clk_i);
      #1;
      b = '{8'h11, 8'h22, 8'h33, 8'h44};
      fetch(32'h44, b, 0, 4, rd, er, lat, tg);
      check("arst_fetch_rdata", rd, model_word(b));
      check("arst_fetch_err", 32'(er), 32'd0);
      check_tx(32'h44, "arst_fetch");

      // Back-to-back with mem_valid_i held high across both requests.
      tr_mode = 0;
      tx_q.delete();
      p0 = pulses;
      b  = '{8'h01, 8'h02, 8'h03, 8'h04};
      b2 = '{8'hf1, 8'he2, 8'hd3, 8'hc4};
      mem_addr_i  = 32'h0;
      mem_valid_i = 1'b1;
      a1 = 0;
      a2 = 0;
      fork
         begin
            int h;
            wait_tvalid();
            for (int i = 0; i < 4; i++) rx_byte(b[i], 0, h);
            wait_tvalid();
            for (int i = 0; i < 4; i++) rx_byte(b2[i], 0, h);
         end
         begin
            wait_ready(rd1, er1, a1);
            mem_addr_i = 32'h4;
            wait_ready(rd2, er2, a2);
         end
      join
      mem_valid_i = 1'b0;
      check("b2b_rdata0", rd1, model_word(b));
      check("b2b_rdata1", rd2, model_word(b2));
      check("b2b_err", 32'({er1, er2}), 32'd0);
      check("b2b_spacing", 32'(a2 - a1), 32'd10);
      check("b2b_pulses", 32'(pulses - p0), 32'd2);
      check("b2b_txcount", 32'(tx_q.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         if (i < tx_q.size())
            check("b2b_txbyte", 32'(tx_q[i]), 32'(model_txb((i < 4) ? 32'h0 : 32'h4, i % 4)));

      // Randomized fetches against the model.
      for (int k = 0; k < 20; k++) begin
         logic [31:0] a;
         a = $urandom;
         for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 255));
         tr_mode = $urandom_range(0, 2);
         fetch(a, b, -1, 4, rd, er, lat, tg);
         check("rand_rdata", rd, model_word(b));
         check("rand_err", 32'(er), 32'd0);
         check_tx(a, "rand");
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk_i);
            #1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
